// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop RX synchronizer, mid-bit sampling FSM, sticky
// ready / framing-error / overrun flags for the consuming logic.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                rx_meta_q;
  logic                rx_s_q;
  logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rdy_q, rdy_d;
  logic                frm_err_q, frm_err_d;
  logic                ovr_err_q, ovr_err_d;

  // Next-state, counter and flag logic; clr_rdy is the default action and a
  // good-frame completion in the same cycle overrides it.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rdy_d      = clr_rdy ? 1'b0 : rdy_q;
    ovr_err_d  = clr_rdy ? 1'b0 : ovr_err_q;
    frm_err_d  = frm_err_q;

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end

      START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_cnt_d = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (baud_cnt_q == FULL_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s_q, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (baud_cnt_q == FULL_LAST) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
          if (rx_s_q) begin
            rx_data_d = shift_q;
            rdy_d     = 1'b1;
            frm_err_d = 1'b0;
            if (rdy_q && !clr_rdy) begin
              ovr_err_d = 1'b1;
            end
          end else begin
            frm_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  // All state, including the synchronizer, resets asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rdy_q      <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= RX;
      rx_s_q     <= rx_meta_q;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      frm_err_q  <= frm_err_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_err_q;
  assign ovr_err = ovr_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: good frames, framing
// error, overrun, clear/complete collision, start glitch and mid-frame reset.
module tb_uart_rx;

  localparam int unsigned N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int lat;
  logic rdy_prev = 1'b0;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge count at which rdy was first seen high
  always @(negedge clk) begin
    if (rdy && !rdy_prev) rise_cyc = cyc;
    rdy_prev = rdy;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the first nbits of {stop, data, start}, LSB first; optionally pulse
  // clr_rdy on exactly the cycle the receiver completes the frame.
  task automatic drive_frame(input logic [7:0] d, input logic stop_b, input int nbits,
                             input logic clr_done);
    logic [9:0] f;
    f = {stop_b, d, 1'b0};
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int b = 0; b < nbits; b++) begin
      RX = f[b];
      for (int i = 0; i < int'(N); i++) begin
        @(posedge clk); #1;
        if (b == 9 && i == 9)  clr_rdy = clr_done;
        if (b == 9 && i == 10) clr_rdy = 1'b0;
      end
    end
    RX = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_rdy = 1'b1;
    @(posedge clk); #1;
    clr_rdy = 1'b0;
  endtask

  task automatic check_good(input string tag, input logic [7:0] d, input logic ovr);
    @(negedge clk);
    check({tag, "_data"}, 16'(rx_data), 16'(d));
    check({tag, "_rdy"},  16'(rdy),     16'd1);
    check({tag, "_frm"},  16'(frm_err), 16'd0);
    check({tag, "_ovr"},  16'(ovr_err), 16'(ovr));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 16'(rx_data), 16'h00);
    check("rst_rdy",  16'(rdy),     16'd0);
    check("rst_frm",  16'(frm_err), 16'd0);
    check("rst_ovr",  16'(ovr_err), 16'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // 0x5A with latency from start edge
    drive_frame(8'h5A, 1'b1, 10, 1'b0);
    lat = rise_cyc - start_cyc;
    tests++;
    assert (lat >= 154 && lat <= 156) else begin
      fails++;
      $error("FAIL latency observed=%0d expected=155+-1", lat);
    end
    check_good("f5a", 8'h5A, 1'b0);
    pulse_clr();
    @(negedge clk);
    check("clr_rdy", 16'(rdy), 16'd0);

    // Back-to-back 00, FF, A5 with clears
    drive_frame(8'h00, 1'b1, 10, 1'b0);
    check_good("f00", 8'h00, 1'b0);
    pulse_clr();
    drive_frame(8'hFF, 1'b1, 10, 1'b0);
    check_good("fff", 8'hFF, 1'b0);
    pulse_clr();
    drive_frame(8'hA5, 1'b1, 10, 1'b0);
    check_good("fa5", 8'hA5, 1'b0);
    pulse_clr();

    // Framing error keeps data, then a good frame clears frm_err
    drive_frame(8'h3C, 1'b0, 10, 1'b0);
    @(negedge clk);
    check("ferr_frm",  16'(frm_err), 16'd1);
    check("ferr_rdy",  16'(rdy),     16'd0);
    check("ferr_data", 16'(rx_data), 16'hA5);
    repeat (2 * N) @(posedge clk);
    drive_frame(8'h81, 1'b1, 10, 1'b0);
    check_good("f81", 8'h81, 1'b0);
    pulse_clr();

    // Overrun
    drive_frame(8'h11, 1'b1, 10, 1'b0);
    check_good("f11", 8'h11, 1'b0);
    drive_frame(8'h22, 1'b1, 10, 1'b0);
    check_good("f22", 8'h22, 1'b1);
    pulse_clr();
    @(negedge clk);
    check("ovr_clr_rdy", 16'(rdy),     16'd0);
    check("ovr_clr_ovr", 16'(ovr_err), 16'd0);

    // Start glitch of 5 clocks is ignored
    @(posedge clk); #1;
    RX = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    RX = 1'b1;
    repeat (2 * N) @(posedge clk);
    @(negedge clk);
    check("gl_state", 16'(dut.state_q), 16'd0);
    check("gl_rdy",   16'(rdy),         16'd0);
    check("gl_data",  16'(rx_data),     16'h22);
    check("gl_frm",   16'(frm_err),     16'd0);
    check("gl_ovr",   16'(ovr_err),     16'd0);
    drive_frame(8'h77, 1'b1, 10, 1'b0);
    check_good("f77", 8'h77, 1'b0);

    // clr_rdy coinciding with completion while rdy is high: completion wins, no overrun
    drive_frame(8'h99, 1'b1, 10, 1'b1);
    check_good("f99", 8'h99, 1'b0);

    // Reset during data bit 4 of a frame
    drive_frame(8'h00, 1'b1, 5, 1'b0);
    RX = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("mrst_data",  16'(rx_data),     16'h00);
    check("mrst_rdy",   16'(rdy),         16'd0);
    check("mrst_frm",   16'(frm_err),     16'd0);
    check("mrst_ovr",   16'(ovr_err),     16'd0);
    check("mrst_state", 16'(dut.state_q), 16'd0);
    RX = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3 * N) @(posedge clk);
    drive_frame(8'hC3, 1'b1, 10, 1'b0);
    check_good("fc3", 8'hC3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the segway 8N1 UART link. It is the receive-side counterpart of the team's UART transmitter, runs at the same bit period and handles the same frame format. It synchronizes the asynchronous RX line, detects the start bit and samples each bit at mid-period. It then presents the byte with a sticky ready flag plus framing and overrun error flags to the consuming logic (command decoder / telemetry path).

## Interface
- CLKS_PER_BIT, default 8192: clocks per bit; must match the transmitter's baud divider; even, >= 16
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous reset, active-high
- RX  input  1  serial line, idle high, asynchronous to clk
- clr_rdy  input  1  one-clock pulse from the consumer; clears rdy and ovr_err
- rx_data  output  8  last correctly framed byte, LSB received first
- rdy  output  1  high when rx_data holds an unread byte; sticky until clr_rdy
- frm_err  output  1  last frame had stop bit = 0; sticky
- ovr_err  output  1  a byte completed while rdy was already high; sticky

## Operation
- Synchronizer: RX passes through two flops, both reset to 1; rx_s is the second flop. The FSM sees only rx_s.
- Counters:
  - baud_cnt is $clog2(CLKS_PER_BIT) bits wide; it is cleared on every state change and counts up otherwise.
  - bit_cnt is 4 bits wide and counts data bits 0..8.
  - shift is an 8-bit right-shift register; a new bit enters the MSB.
- FSM states are IDLE, START, DATA, STOP.
- IDLE: when rx_s == 0, go to START with baud_cnt = 0.
- START: at baud_cnt == CLKS_PER_BIT/2-1, sample rx_s.
  - rx_s == 0: go to DATA with bit_cnt = 0.
  - rx_s == 1: false start (glitch); return to IDLE and leave outputs untouched.
- DATA: at baud_cnt == CLKS_PER_BIT-1, shift <= {rx_s, shift[7:1]} and increment bit_cnt. When the 8th bit is taken, go to STOP.
- STOP: at baud_cnt == CLKS_PER_BIT-1, sample rx_s, then return to IDLE (at mid stop bit, so back-to-back frames are accepted).
  - rx_s == 1 (good frame): rx_data <= shift, rdy <= 1, frm_err <= 0. If rdy was already 1 and no clr_rdy in that cycle, ovr_err <= 1; rx_data is still overwritten with the newest byte.
  - rx_s == 0 (framing error): frm_err <= 1. rx_data, rdy and ovr_err are unchanged.
- clr_rdy clears rdy and ovr_err on the next edge; it has no effect on frm_err or the FSM.
- clr_rdy in the same cycle as a good-frame completion: completion wins. rdy = 1, ovr_err = 0, rx_data holds the new byte.
- RX activity while rdy is high is still received; reception never stalls.

## Timing
- Reset values:
  - rx_data = 8'h00, rdy = 0, frm_err = 0, ovr_err = 0
  - state = IDLE, sync flops = 1, baud_cnt = 0, bit_cnt = 0
- Reset mid-frame: all of the above apply immediately (asynchronous). After release, the receiver waits in IDLE for the next falling rx_s. The remainder of the interrupted frame may be seen as a new start, and it must resolve as a false start, a framing error, or a byte; it must never hang.
- Synchronizer latency: 2 clocks from an RX edge to rx_s.
- Sample points, relative to the cycle rx_s first reads 0:
  - start check: CLKS_PER_BIT/2 clocks
  - data bit k (k = 0..7): CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT
  - stop check: CLKS_PER_BIT/2 + 9*CLKS_PER_BIT
- rdy, rx_data and frm_err update 1 clock after the stop sample. Total is 9.5*CLKS_PER_BIT + 3 clocks ±1 from the RX falling edge.
- Tolerates a transmitter bit-period mismatch of up to ±4%.
- A start-bit low pulse shorter than CLKS_PER_BIT/2 clocks produces no output change.

## Test plan
- CLKS_PER_BIT = 16: drive frame 0x5A (LSB first, stop = 1). Required: rdy rises within 155±1 clocks of the start edge, rx_data = 8'h5A, frm_err = 0, ovr_err = 0. Then pulse clr_rdy: rdy = 0 on the next clock.
- Loopback with the team UART transmitter, CLKS_PER_BIT = 8192: send 0x00, 0xFF, 0xA5 back to back, clearing rdy after each. Required: three rdy assertions with rx_data = 00, FF, A5, and no error flags.
- Send 0x3C with stop bit forced to 0. Required: frm_err = 1, rdy stays 0, rx_data keeps its prior value. Then send good frame 0x81. Required: frm_err = 0, rdy = 1, rx_data = 8'h81.
- Send 0x11 and 0x22 without clr_rdy. Required: rdy = 1, rx_data = 8'h22, ovr_err = 1. Then clr_rdy clears rdy and ovr_err.
- Drive an RX low glitch of 5 clocks (CLKS_PER_BIT = 16). Required: FSM returns to IDLE, all outputs unchanged. Then a following valid 0x77 is received correctly.
- Assert rst during data bit 4 of a frame. Required: all outputs take reset values the same cycle. After release, the next full frame 0xC3 gives rx_data = 8'hC3 and rdy = 1.
